sram_access_sequencer: RTL and testbench

Sequencer on the QX-10/16 1MB memory expansion card, directly downstream of the bank-register memory controller. It consumes the controller's gated request and chip-select strobes (nmemrq, nmemrd, nmemwr, nce1, nce2) and produces properly ordered SRAM strobes, data-transceiver controls and a bus wait (nrdy). Address setup, strobe width, write hold and recovery are guaranteed in card-clock cycles.

---
 rtl/memx_pkg.sv | 35 +++
 rtl/memx_sync.sv | 37 +++
 rtl/sram_access_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_sram_access_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/memx_pkg.sv
// -----------------------------------------------------------------------------
// memx_pkg
// Shared definitions for the 1MB memory expansion card:
//   - state_t      : SRAM access sequencer states
//   - CNT_W        : width of the sequencer's per-state cycle counter
//   - DEF_*_CYC    : default access timing, in card-clock cycles. The bank
//                    controller bench uses the same values.
//   - cnt_load()   : counter preload for a state lasting N cycles
// -----------------------------------------------------------------------------
package memx_pkg;

    localparam int CNT_W = 3;

    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_WAIT_CYC  = 2;
    localparam int DEF_HOLD_CYC  = 1;
    localparam int DEF_RECOV_CYC = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACTIVE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4,
        RECOV  = 3'd5
    } state_t;

    // The counter holds the number of cycles still to go after the current
    // one, so a state lasting N cycles is entered with N-1. States with N=0
    // are bypassed by the caller and never load this value.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return (cycles > 0) ? CNT_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/memx_sync.sv
// -----------------------------------------------------------------------------
// memx_sync
// Parameterised-width two-flop synchroniser for asynchronous bus strobes.
// Both stages reset to RST_VAL so active-low strobes come up deasserted.
//
// Ports:
//   clk   in   card clock
//   nrst  in   asynchronous active-low reset
//   i_d   in   [W-1:0] asynchronous inputs
//   o_q   out  [W-1:0] synchronised outputs (2 clk latency)
// -----------------------------------------------------------------------------
module memx_sync #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// sram_access_sequencer
// Turns the bank controller's gated request/strobe/chip-select signals into
// correctly ordered SRAM strobes, data transceiver controls and a CPU wait.
// Setup, strobe width, write hold and recovery are counted in card clocks.
//
// Parameters (0..7 each):
//   SETUP_CYC  cycles of chip select before noe/nwe
//   WAIT_CYC   strobe width is WAIT_CYC+1 cycles
//   HOLD_CYC   write: cycles of chip select after nwe rises
//   RECOV_CYC  idle cycles before the next access may start
//
// Ports:
//   clk                   in   card clock (>= 4x CPU clock)
//   nrst                  in   asynchronous active-low reset
//   nmemrq                in   gated memory request, active-low, async
//   nmemrd, nmemwr        in   gated read/write strobes, active-low, async
//   nce1_in, nce2_in      in   bank chip selects, active-low
//   sram_nce1, sram_nce2  out  SRAM chip enables, active-low
//   sram_noe, sram_nwe    out  SRAM output/write enables, active-low
//   buf_noe               out  data transceiver enable, active-low
//   buf_dir               out  1 = card drives CPU bus (read)
//   nrdy                  out  CPU wait, 0 = stretch cycle
//   busy                  out  1 while not IDLE
//   cycle_err             out  one-clock pulse on aborted/illegal cycle
// -----------------------------------------------------------------------------
module sram_access_sequencer
    import memx_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WAIT_CYC  = DEF_WAIT_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int RECOV_CYC = DEF_RECOV_CYC
) (
    input  logic clk,
    input  logic nrst,
    input  logic nmemrq,
    input  logic nmemrd,
    input  logic nmemwr,
    input  logic nce1_in,
    input  logic nce2_in,
    output logic sram_nce1,
    output logic sram_nce2,
    output logic sram_noe,
    output logic sram_nwe,
    output logic buf_noe,
    output logic buf_dir,
    output logic nrdy,
    output logic busy,
    output logic cycle_err
);

    // ---------------------------------------------------------------- sync
    logic [2:0] w_sync;
    logic       w_rq;
    logic       w_rd;
    logic       w_wr;

    memx_sync #(
        .W       (3),
        .RST_VAL (3'b111)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .i_d  ({nmemrq, nmemrd, nmemwr}),
        .o_q  (w_sync)
    );

    // Active-high views of the synchronised strobes.
    assign w_rq = ~w_sync[2];
    assign w_rd = ~w_sync[1];
    assign w_wr = ~w_sync[0];

    // ---------------------------------------------------------------- state
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_read;
    logic             r_use_ce2;
    logic             r_live;      // access actually drives SRAM strobes

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_is_read_next;
    logic             w_use_ce2_next;
    logic             w_live_next;
    logic             w_leave;     // request released: head for recovery
    logic             w_err_next;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_is_read_next = r_is_read;
        w_use_ce2_next = r_use_ce2;
        w_live_next    = r_live;
        w_leave        = 1'b0;
        w_err_next     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_rq) begin
                    if (w_rd && w_wr) begin
                        w_err_next   = 1'b1;
                        w_live_next  = 1'b0;
                        w_state_next = DONE;
                        w_cnt_next   = '0;
                    end else if (w_rd || w_wr) begin
                        w_is_read_next = w_rd;
                        if (!nce1_in || !nce2_in) begin
                            // nce1 has priority when both banks select.
                            w_use_ce2_next = nce1_in;
                            w_live_next    = 1'b1;
                            if (SETUP_CYC == 0) begin
                                w_state_next = ACTIVE;
                                w_cnt_next   = CNT_W'(WAIT_CYC);
                            end else begin
                                w_state_next = SETUP;
                                w_cnt_next   = cnt_load(SETUP_CYC);
                            end
                        end else begin
                            // Bank disabled: acknowledge without strobes.
                            w_live_next  = 1'b0;
                            w_state_next = DONE;
                            w_cnt_next   = '0;
                        end
                    end
                end
            end
            SETUP: begin
                if (!w_rq) begin
                    w_leave = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_next = ACTIVE;
                    w_cnt_next   = CNT_W'(WAIT_CYC);
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ACTIVE: begin
                if (!w_rq) begin
                    w_leave = 1'b1;
                end else if (r_cnt == '0) begin
                    if (r_is_read || HOLD_CYC == 0) begin
                        w_state_next = DONE;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = HOLD;
                        w_cnt_next   = cnt_load(HOLD_CYC);
                    end
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (!w_rq) begin
                    w_leave = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_next = DONE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (!w_rq) begin
                    w_leave = 1'b1;
                end
            end
            RECOV: begin
                if (r_cnt == '0) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Leaving DONE is the normal end of a cycle; leaving any earlier
        // state means the CPU dropped the request mid-access.
        if (w_leave) begin
            w_err_next = (r_state != DONE);
            if (RECOV_CYC == 0) begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end else begin
                w_state_next = RECOV;
                w_cnt_next   = cnt_load(RECOV_CYC);
            end
        end
    end

    // ------------------------------------------------------ output decode
    // Outputs are decoded from the next state so each one is a plain flop.
    logic w_ce_low;
    logic w_buf_low;
    logic w_dir_next;
    logic w_noe_low;
    logic w_nwe_low;
    logic w_nrdy_low;

    always_comb begin
        w_ce_low   = 1'b0;
        w_buf_low  = 1'b0;
        w_dir_next = 1'b0;
        w_noe_low  = 1'b0;
        w_nwe_low  = 1'b0;
        w_nrdy_low = 1'b0;

        case (w_state_next)
            SETUP: begin
                w_ce_low   = 1'b1;
                w_buf_low  = 1'b1;
                w_dir_next = w_is_read_next;
                w_nrdy_low = 1'b1;
            end
            ACTIVE: begin
                w_ce_low   = 1'b1;
                w_buf_low  = 1'b1;
                w_dir_next = w_is_read_next;
                w_noe_low  = w_is_read_next;
                w_nwe_low  = ~w_is_read_next;
                w_nrdy_low = 1'b1;
            end
            HOLD: begin
                w_ce_low  = 1'b1;
                w_buf_low = 1'b1;
            end
            DONE: begin
                // Read data must stay on the bus until the CPU releases it.
                if (w_live_next && w_is_read_next) begin
                    w_ce_low   = 1'b1;
                    w_buf_low  = 1'b1;
                    w_dir_next = 1'b1;
                    w_noe_low  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    logic r_nce1;
    logic r_nce2;
    logic r_noe;
    logic r_nwe;
    logic r_buf_noe;
    logic r_buf_dir;
    logic r_nrdy;
    logic r_busy;
    logic r_err;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_is_read <= 1'b0;
            r_use_ce2 <= 1'b0;
            r_live    <= 1'b0;
            r_nce1    <= 1'b1;
            r_nce2    <= 1'b1;
            r_noe     <= 1'b1;
            r_nwe     <= 1'b1;
            r_buf_noe <= 1'b1;
            r_buf_dir <= 1'b0;
            r_nrdy    <= 1'b1;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_is_read <= w_is_read_next;
            r_use_ce2 <= w_use_ce2_next;
            r_live    <= w_live_next;
            r_nce1    <= ~(w_ce_low & ~w_use_ce2_next);
            r_nce2    <= ~(w_ce_low & w_use_ce2_next);
            r_noe     <= ~w_noe_low;
            r_nwe     <= ~w_nwe_low;
            r_buf_noe <= ~w_buf_low;
            r_buf_dir <= w_dir_next;
            r_nrdy    <= ~w_nrdy_low;
            r_busy    <= (w_state_next != IDLE);
            r_err     <= w_err_next;
        end
    end

    assign sram_nce1 = r_nce1;
    assign sram_nce2 = r_nce2;
    assign sram_noe  = r_noe;
    assign sram_nwe  = r_nwe;
    assign buf_noe   = r_buf_noe;
    assign buf_dir   = r_buf_dir;
    assign nrdy      = r_nrdy;
    assign busy      = r_busy;
    assign cycle_err = r_err;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_access_sequencer
// Two sequencers share one stimulus: u_dut0 with default timing and u_dut1
// with WAIT_CYC=5. For every access the bench paints the expected output
// timeline (interval arithmetic from request/release edges) into a per-cycle
// table; a single compare process checks both DUTs against it every cycle.
// Output vector order: {nce1,nce2,noe,nwe,buf_noe,buf_dir,nrdy,busy,err}.
// -----------------------------------------------------------------------------
module tb_sram_access_sequencer;

    localparam int S_C   = 1;
    localparam int H_C   = 1;
    localparam int R_C   = 1;
    localparam int NCYC  = 1024;
    localparam logic [8:0] IDLE_V = 9'b111110100;

    // bit positions in the output vector
    localparam int B_NCE1 = 8, B_NCE2 = 7, B_NOE = 6, B_NWE = 5, B_BNOE = 4;
    localparam int B_BDIR = 3, B_NRDY = 2, B_BUSY = 1, B_ERR = 0;

    // access kinds
    localparam int K_RD = 0, K_WR = 1, K_NOBANK = 2, K_ILLEGAL = 3;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic nmemrq = 1'b1;
    logic nmemrd = 1'b1;
    logic nmemwr = 1'b1;
    logic nce1_in = 1'b1;
    logic nce2_in = 1'b1;

    always #5 clk = ~clk;

    logic a_nce1, a_nce2, a_noe, a_nwe, a_bnoe, a_bdir, a_nrdy, a_busy, a_err;
    logic b_nce1, b_nce2, b_noe, b_nwe, b_bnoe, b_bdir, b_nrdy, b_busy, b_err;

    sram_access_sequencer u_dut0 (
        .clk(clk), .nrst(nrst), .nmemrq(nmemrq), .nmemrd(nmemrd), .nmemwr(nmemwr),
        .nce1_in(nce1_in), .nce2_in(nce2_in),
        .sram_nce1(a_nce1), .sram_nce2(a_nce2), .sram_noe(a_noe), .sram_nwe(a_nwe),
        .buf_noe(a_bnoe), .buf_dir(a_bdir), .nrdy(a_nrdy), .busy(a_busy),
        .cycle_err(a_err)
    );

    sram_access_sequencer #(.WAIT_CYC(5)) u_dut1 (
        .clk(clk), .nrst(nrst), .nmemrq(nmemrq), .nmemrd(nmemrd), .nmemwr(nmemwr),
        .nce1_in(nce1_in), .nce2_in(nce2_in),
        .sram_nce1(b_nce1), .sram_nce2(b_nce2), .sram_noe(b_noe), .sram_nwe(b_nwe),
        .buf_noe(b_bnoe), .buf_dir(b_bdir), .nrdy(b_nrdy), .busy(b_busy),
        .cycle_err(b_err)
    );

    wire [8:0] dut0_v = {a_nce1, a_nce2, a_noe, a_nwe, a_bnoe, a_bdir, a_nrdy, a_busy, a_err};
    wire [8:0] dut1_v = {b_nce1, b_nce2, b_noe, b_nwe, b_bnoe, b_bdir, b_nrdy, b_busy, b_err};

    int         cyc = 0;
    logic [8:0] exp_v [2][NCYC];
    int         last_idle [2];
    int         n_checks = 0;
    int         n_pass = 0;
    bit         chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%b required=%b", name, act, req);
    endtask

    // every-cycle comparison of both DUTs against the painted timeline
    always @(negedge clk) begin
        if (chk_en && cyc < NCYC) begin
            for (int d = 0; d < 2; d++)
                check($sformatf("dut%0d_cyc%0d", d, cyc), (d == 0) ? dut0_v : dut1_v,
                      exp_v[d][cyc]);
        end
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic paint(input int d, input int b, input int from, input int to, input logic val);
        for (int c = from; c < to && c < NCYC; c++) exp_v[d][c][b] = val;
    endtask

    task automatic clear_from(input int d, input int from);
        for (int c = from; c < NCYC; c++) exp_v[d][c] = IDLE_V;
    endtask

    // Expected timeline of one access. Request is driven just after edge t0
    // and released just after edge tr; the synchroniser adds 2 edges and the
    // output register 1, so effects land on edge t0+3 / tr+3 at the earliest.
    task automatic model_txn(input int d, input int t0, input int tr, input int kind,
                             input bit ce2);
        int w, start, rel, as_, ae, pe, ceb;
        w     = (d == 0) ? 2 : 5;
        start = t0 + 3;
        if (last_idle[d] + 1 > start) start = last_idle[d] + 1;
        rel   = tr + 3;
        paint(d, B_BUSY, start, rel + R_C, 1'b1);
        last_idle[d] = rel + R_C;
        if (kind == K_ILLEGAL) paint(d, B_ERR, start, start + 1, 1'b1);
        if (kind == K_RD || kind == K_WR) begin
            as_ = start + S_C;                 // strobe falls
            ae  = as_ + w + 1;                 // strobe window ends
            pe  = (kind == K_WR) ? ae + H_C : ae;
            ceb = ce2 ? B_NCE2 : B_NCE1;
            if (rel <= pe) paint(d, B_ERR, rel, rel + 1, 1'b1);
            paint(d, B_NRDY, start, imin(ae, rel), 1'b0);
            if (kind == K_RD) begin
                paint(d, ceb, start, rel, 1'b0);
                paint(d, B_BNOE, start, rel, 1'b0);
                paint(d, B_BDIR, start, rel, 1'b1);
                paint(d, B_NOE, as_, rel, 1'b0);
            end else begin
                paint(d, ceb, start, imin(pe, rel), 1'b0);
                paint(d, B_BNOE, start, imin(pe, rel), 1'b0);
                paint(d, B_NWE, as_, imin(ae, rel), 1'b0);
            end
        end
    endtask

    task automatic drive_req(input int kind, input bit ce2);
        nce1_in = (kind == K_NOBANK) ? 1'b1 : ce2;
        nce2_in = (kind == K_NOBANK) ? 1'b1 : ~ce2;
        nmemrd  = ~(kind == K_RD || kind == K_NOBANK || kind == K_ILLEGAL);
        nmemwr  = ~(kind == K_WR || kind == K_ILLEGAL);
        nmemrq  = 1'b0;
    endtask

    task automatic issue(input int kind, input bit ce2, input int hold, output int t0);
        @(posedge clk); #1;
        t0 = cyc;
        for (int d = 0; d < 2; d++) model_txn(d, t0, t0 + hold, kind, ce2);
        drive_req(kind, ce2);
        repeat (hold) @(posedge clk);
        #1;
        nmemrq = 1'b1; nmemrd = 1'b1; nmemwr = 1'b1;
    endtask

    task automatic settle();
        int tgt;
        tgt = ((last_idle[0] > last_idle[1]) ? last_idle[0] : last_idle[1]) + 2;
        while (cyc < tgt) @(posedge clk);
    endtask

    task automatic pin(input string name, input int d, input int c, input logic [8:0] lit);
        check(name, exp_v[d][c], lit);
    endtask

    initial begin
        int t0, t1;
        for (int d = 0; d < 2; d++) clear_from(d, 0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", dut0_v, IDLE_V);
        check("reset_dut1", dut1_v, IDLE_V);
        #1 nrst = 1'b1;
        last_idle[0] = cyc; last_idle[1] = cyc;
        chk_en = 1'b1;

        // read, bank 1
        issue(K_RD, 1'b0, 10, t0);
        pin("rd_pre",    0, t0 + 2,  9'b111110100);
        pin("rd_ce",     0, t0 + 3,  9'b011101010);
        pin("rd_noe",    0, t0 + 4,  9'b010101010);
        pin("rd_rdy",    0, t0 + 7,  9'b010101110);
        pin("rd_rel",    0, t0 + 13, 9'b111110110);
        settle();

        // write, bank 2
        issue(K_WR, 1'b1, 10, t0);
        pin("wr_nwe",    0, t0 + 6, 9'b101000010);
        pin("wr_hold",   0, t0 + 7, 9'b101100110);
        pin("wr_done",   0, t0 + 8, 9'b111110110);
        settle();

        // bank disabled
        issue(K_NOBANK, 1'b0, 6, t0);
        pin("nobank",    0, t0 + 3, 9'b111110110);
        settle();

        // read and write together
        issue(K_ILLEGAL, 1'b0, 6, t0);
        pin("illegal",   0, t0 + 3, 9'b111110111);
        settle();

        // request released in the middle of ACTIVE
        issue(K_RD, 1'b0, 3, t0);
        pin("abort_act", 1, t0 + 5, 9'b010101010);
        pin("abort_err", 1, t0 + 6, 9'b111110111);
        pin("abort_idl", 1, t0 + 7, 9'b111110100);
        settle();

        // back-to-back reads, second presented while the first recovers
        issue(K_RD, 1'b0, 10, t0);
        issue(K_RD, 1'b1, 10, t1);
        pin("b2b_recov", 0, t0 + 13, 9'b111110110);
        pin("b2b_gap",   0, t0 + 14, 9'b111110100);
        pin("b2b_start", 0, t0 + 15, 9'b101101010);
        settle();

        // reset in the middle of a write strobe
        @(posedge clk); #1;
        t0 = cyc;
        for (int d = 0; d < 2; d++) model_txn(d, t0, t0 + 20, K_WR, 1'b0);
        drive_req(K_WR, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        chk_en = 1'b0;
        nrst = 1'b0;
        nmemrq = 1'b1; nmemrd = 1'b1; nmemwr = 1'b1;
        #1;
        check("rst_async_dut0", dut0_v, IDLE_V);
        check("rst_async_dut1", dut1_v, IDLE_V);
        for (int d = 0; d < 2; d++) clear_from(d, cyc);
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
        last_idle[0] = cyc; last_idle[1] = cyc;
        chk_en = 1'b1;

        // a fresh read after reset completes normally
        issue(K_RD, 1'b0, 10, t0);
        pin("post_rst",  0, t0 + 4, 9'b010101010);
        settle();

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
